// File: rtl/control_module_pkg.sv
// Shared constants and types for the multicycle MIPS main control FSM.
// Opcode values, state encodings, datapath select encodings and the control bundle.
package control_module_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned SRCB_W  = 3;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned PCSRC_W = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;

    // Encodings 13..15 are unused and recover to FETCH.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXEC     = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDIEXEC = 4'd10,
        S_IMMWB    = 4'd11,
        S_ORIEXEC  = 4'd12
    } state_t;

    typedef enum logic [SRCB_W-1:0] {
        SRCB_REGB     = 3'b000,
        SRCB_FOUR     = 3'b001,
        SRCB_SEXT     = 3'b010,
        SRCB_SEXT_SH2 = 3'b011,
        SRCB_ZEXT     = 3'b100
    } srcb_t;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_t;

    typedef enum logic [PCSRC_W-1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_t;

    // Datapath control bundle driven by the FSM.
    typedef struct packed {
        logic   mem_write;
        logic   ir_write;
        logic   mem_to_reg;
        logic   reg_dst;
        logic   reg_write;
        logic   alu_src_a;
        srcb_t  alu_src_b;
        aluop_t alu_op;
        pcsrc_t pc_source;
        logic   pc_write_cond;
        logic   pc_write;
        logic   i_or_d;
    } ctrl_t;

endpackage

// File: rtl/control_output_decoder.sv
// Moore output table: maps the current FSM state to the datapath control bundle.
// The ORIEXEC row exists only when CTRL_ORI_EN is defined.
module control_output_decoder
    import control_module_pkg::*;
(
    input  state_t i_state,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.alu_src_a = 1'b0;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                o_ctrl.i_or_d    = 1'b0;
            end
            // Branch target is precomputed while the opcode is being decoded.
            S_DECODE: begin
                o_ctrl.alu_src_b = SRCB_SEXT_SH2;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_SEXT;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                o_ctrl.i_or_d = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_dst    = 1'b0;
            end
            S_MEMWR: begin
                o_ctrl.i_or_d    = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REGB;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_REGB;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
                o_ctrl.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_source = PCSRC_JUMP;
                o_ctrl.pc_write  = 1'b1;
            end
            S_ADDIEXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_SEXT;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_IMMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 1'b0;
                o_ctrl.mem_to_reg = 1'b0;
            end
`ifdef CTRL_ORI_EN
            S_ORIEXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_ZEXT;
                o_ctrl.alu_op    = ALUOP_OR;
            end
`endif
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_module.sv
// Multicycle MIPS main control FSM: state register, next-state logic and reset gating.
// Optional ORI support is enabled by defining CTRL_ORI_EN.
module control_module
    import control_module_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    Op_code,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [SRCB_W-1:0]  ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [PCSRC_W-1:0] PCSource,
    output logic               PCWriteCond,
    output logic               PCWrite,
    output logic               IorD
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_dec;
    ctrl_t  w_ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode only steers the FSM in DECODE and MEMADR.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (Op_code)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDIEXEC;
`ifdef CTRL_ORI_EN
                    OP_ORI:       w_next = S_ORIEXEC;
`endif
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (Op_code == OP_LW) begin
                    w_next = S_MEMRD;
                end else if (Op_code == OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEMRD:    w_next = S_MEMWB;
            S_EXEC:     w_next = S_ALUWB;
            S_ADDIEXEC: w_next = S_IMMWB;
`ifdef CTRL_ORI_EN
            S_ORIEXEC:  w_next = S_IMMWB;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    control_output_decoder u_decoder (
        .i_state (r_state),
        .o_ctrl  (w_dec)
    );

    // Reset suppresses every control output in the same cycle, including write enables.
    assign w_ctrl = rst ? ctrl_t'('0) : w_dec;

    assign MemWrite    = w_ctrl.mem_write;
    assign IRWrite     = w_ctrl.ir_write;
    assign MemtoReg    = w_ctrl.mem_to_reg;
    assign RegDst      = w_ctrl.reg_dst;
    assign RegWrite    = w_ctrl.reg_write;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign ALUOp       = w_ctrl.alu_op;
    assign PCSource    = w_ctrl.pc_source;
    assign PCWriteCond = w_ctrl.pc_write_cond;
    assign PCWrite     = w_ctrl.pc_write;
    assign IorD        = w_ctrl.i_or_d;

endmodule

// File: tb/tb_control_module.sv
// Scoreboard bench for control_module: per-instruction expected control sequences are queued
// by the stimulus process and compared cycle by cycle by an independent monitor.
module tb_control_module;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_ORI   = 6'b001101;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op_code;
    logic       MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [2:0] ALUSrcB;
    logic [1:0] ALUOp, PCSource;
    logic       PCWriteCond, PCWrite, IorD;

    typedef struct packed {
        logic       mw;
        logic       irw;
        logic       m2r;
        logic       rdst;
        logic       rw;
        logic       srca;
        logic [2:0] srcb;
        logic [1:0] aluop;
        logic [1:0] pcs;
        logic       pwc;
        logic       pw;
        logic       iord;
    } exp_t;

    exp_t exp_q[$];
    exp_t seq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    control_module dut (
        .clk         (clk),
        .rst         (rst),
        .Op_code     (Op_code),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .PCWriteCond (PCWriteCond),
        .PCWrite     (PCWrite),
        .IorD        (IorD)
    );

    always #5 clk = ~clk;

    // One control word from the datapath's point of view: unnamed signals are 0.
    function automatic exp_t cw(input logic mw, input logic irw, input logic m2r,
                                input logic rdst, input logic rw, input logic srca,
                                input logic [2:0] srcb, input logic [1:0] aluop,
                                input logic [1:0] pcs, input logic pwc, input logic pw,
                                input logic iord);
        exp_t e;
        e = '{mw, irw, m2r, rdst, rw, srca, srcb, aluop, pcs, pwc, pw, iord};
        return e;
    endfunction

    // Expected per-cycle control words for a whole instruction, fetch included.
    task automatic build_seq(input logic [5:0] op);
        seq.delete();
        //                 mw irw m2r rd rw sa srcb    aluop  pcs    pwc pw iord
        seq.push_back(cw(0, 1, 0, 0, 0, 0, 3'b001, 2'b00, 2'b00, 0, 1, 0)); // fetch, PC+4
        seq.push_back(cw(0, 0, 0, 0, 0, 0, 3'b011, 2'b00, 2'b00, 0, 0, 0)); // branch target
        case (op)
            T_RTYPE: begin
                seq.push_back(cw(0, 0, 0, 0, 0, 1, 3'b000, 2'b10, 2'b00, 0, 0, 0));
                seq.push_back(cw(0, 0, 0, 1, 1, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0));
            end
            T_LW: begin
                seq.push_back(cw(0, 0, 0, 0, 0, 1, 3'b010, 2'b00, 2'b00, 0, 0, 0));
                seq.push_back(cw(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 1));
                seq.push_back(cw(0, 0, 1, 0, 1, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0));
            end
            T_SW: begin
                seq.push_back(cw(0, 0, 0, 0, 0, 1, 3'b010, 2'b00, 2'b00, 0, 0, 0));
                seq.push_back(cw(1, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 1));
            end
            T_BEQ:
                seq.push_back(cw(0, 0, 0, 0, 0, 1, 3'b000, 2'b01, 2'b01, 1, 0, 0));
            T_J:
                seq.push_back(cw(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b10, 0, 1, 0));
            T_ADDI: begin
                seq.push_back(cw(0, 0, 0, 0, 0, 1, 3'b010, 2'b00, 2'b00, 0, 0, 0));
                seq.push_back(cw(0, 0, 0, 0, 1, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0));
            end
`ifdef CTRL_ORI_EN
            T_ORI: begin
                seq.push_back(cw(0, 0, 0, 0, 0, 1, 3'b100, 2'b11, 2'b00, 0, 0, 0));
                seq.push_back(cw(0, 0, 0, 0, 1, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0));
            end
`endif
            default: ;
        endcase
    endtask

    // Issue one instruction; abort_at >= 0 pulses reset in that cycle of it.
    task automatic run_instr(input logic [5:0] op, input int abort_at);
        int ab;
        int n;
        build_seq(op);
        ab = (abort_at >= 0 && abort_at < seq.size()) ? abort_at : -1;
        if (ab >= 0) begin
            while (seq.size() > ab + 1) void'(seq.pop_back());
            seq[ab] = '0;
        end
        n = seq.size();
        for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
        for (int c = 0; c < n; c++) begin
            // Opcode is held only where it may matter; elsewhere it is scrambled.
            Op_code = (c == 1 || c == 2) ? op : 6'($urandom);
            rst     = (c == ab);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    // Monitor: one expected control word per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        cyc <= cyc + 1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = '{MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                  ALUSrcB, ALUOp, PCSource, PCWriteCond, PCWrite, IorD};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL ctrl_word cycle %0d rst=%0b op=%b: got %h required %h",
                         cyc, rst, Op_code, a, e);
            end
        end
    end

    initial begin
        logic [5:0] ops [8];
        ops[0] = T_RTYPE; ops[1] = T_LW;  ops[2] = T_SW;   ops[3] = T_BEQ;
        ops[4] = T_J;     ops[5] = T_ADDI; ops[6] = T_ORI; ops[7] = 6'b111111;

        rst     = 1'b1;
        Op_code = T_RTYPE;
        exp_q.push_back('0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(T_RTYPE, -1);
        run_instr(T_LW, -1);
        run_instr(T_SW, -1);
        run_instr(T_BEQ, -1);
        run_instr(T_J, -1);
        run_instr(T_ADDI, -1);
        run_instr(6'b111111, -1);
        run_instr(T_ORI, -1);
        run_instr(T_SW, 3);
        run_instr(T_LW, 4);
        run_instr(T_RTYPE, -1);

        for (int k = 0; k < 300; k++) begin
            logic [5:0] op;
            int         ab;
            op = ops[$urandom_range(7)];
            if (op == 6'b111111) op = 6'($urandom);
            ab = ($urandom_range(9) == 0) ? int'($urandom_range(4)) : -1;
            run_instr(op, ab);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
